// File: rtl/sem_mem_rr_arbiter.sv
// Round-robin arbiter giving three CPUs the shared semaphore bit memory port; ARB_HOLD_LIMIT_EN bounds LOCK hold time.
// Latency: one cycle REQ->GNT from idle, back-to-back grants after that; the memory access is combinational in the granted cycle.
// Backpressure: non-owners see RDY=0 and stall until the round-robin reaches them; a LOCKed owner keeps the port.
module sem_mem_rr_arbiter #(
    parameter int AW       = 12,
    parameter int MAX_HOLD = 16,
    parameter int HW       = 5
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic [2:0]    REQ,
    input  logic [2:0]    LOCK,
    input  logic [2:0]    WE,
    input  logic [2:0]    OE,
    input  logic [AW-1:0] A_0,
    input  logic [AW-1:0] A_1,
    input  logic [AW-1:0] A_2,
    input  logic [2:0]    DI,
    output logic [2:0]    GNT,
    output logic [2:0]    RDY,
    output logic [2:0]    DQ,
    output logic [AW-1:0] M_A,
    output logic          M_DI,
    output logic          M_WE,
    output logic          M_OE,
    input  logic          M_DQ,
    output logic          BUSY,
    output logic          ERR
);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] last_q, last_d;
    logic [1:0] owner;
    logic       owner_hold;
    logic       rel;

`ifdef ARB_HOLD_LIMIT_EN
    logic [HW-1:0] hold_q, hold_d;
    logic          err_q, err_d;
`else
    logic [HW-1:0] cfg_unused;
    assign cfg_unused = HW'(MAX_HOLD);
`endif

    // First requester found searching upward from last+1, wrapping; one-hot, zero if none.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [2:0] win;
        int         idx;
        win = 3'b000;
        idx = (last == 2'd2) ? 0 : int'(last) + 1;
        for (int k = 0; k < 3; k++) begin
            if (win == 3'b000 && req[idx]) win[idx] = 1'b1;
            idx = (idx == 2) ? 0 : idx + 1;
        end
        return win;
    endfunction

    // Current owner index from the one-hot grant.
    always_comb begin
        owner = 2'd0;
        if (gnt_q[1])      owner = 2'd1;
        else if (gnt_q[2]) owner = 2'd2;
    end

    assign owner_hold = |(gnt_q & REQ & LOCK);

    // Next-state: pick from idle, enter/leave LOCKED, and re-pick on release with LAST moved to the owner.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        rel     = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        hold_d  = hold_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = rr_pick(REQ, last_q);
                if (gnt_d != 3'b000) state_d = GRANT;
            end
            GRANT: begin
                if (owner_hold) begin
                    state_d = LOCKED;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_d  = '0;
`endif
                end else begin
                    rel = 1'b1;
                end
            end
            LOCKED: begin
                if (!owner_hold) begin
                    rel = 1'b1;
                end else begin
`ifdef ARB_HOLD_LIMIT_EN
                    if (hold_q == HW'(MAX_HOLD - 1)) begin
                        rel   = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
        if (rel) begin
            last_d  = owner;
            gnt_d   = rr_pick(REQ, owner);
            state_d = (gnt_d != 3'b000) ? GRANT : IDLE;
        end
    end

    // Arbiter state registers; reset drops any in-flight access at once.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Hold counter and one-cycle forced-release flag.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            hold_q <= '0;
            err_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            err_q  <= err_d;
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    // Memory port mux: the owner's address; strobes only while the owner still requests.
    always_comb begin
        case (gnt_q)
            3'b001:  M_A = A_0;
            3'b010:  M_A = A_1;
            3'b100:  M_A = A_2;
            default: M_A = '0;
        endcase
    end

    assign GNT  = gnt_q;
    assign RDY  = gnt_q & REQ;
    assign DQ   = gnt_q & {3{M_DQ}};
    assign M_DI = |(gnt_q & DI);
    assign M_WE = |(gnt_q & WE & REQ);
    assign M_OE = |(gnt_q & OE & REQ);
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_sem_mem_rr_arbiter.sv
// Scoreboard bench for sem_mem_rr_arbiter with a behavioural owner/lock reference model.
// Stimulus is applied on the falling edge; expected outputs are queued and checked 2 time units later.
// Directed test-plan sequences are followed by sticky random REQ/LOCK traffic with occasional resets.
module tb_sem_mem_rr_arbiter;

    localparam int AW       = 12;
    localparam int MAX_HOLD = 16;

    logic          CLK = 1'b0;
    logic          CLR;
    logic [2:0]    REQ, LOCK, WE, OE, DI;
    logic [AW-1:0] A_0, A_1, A_2;
    logic [2:0]    GNT, RDY, DQ;
    logic [AW-1:0] M_A;
    logic          M_DI, M_WE, M_OE, M_DQ, BUSY, ERR;

    always #5 CLK = ~CLK;

    sem_mem_rr_arbiter #(.AW(AW), .MAX_HOLD(MAX_HOLD), .HW(5)) dut (
        .CLK(CLK), .CLR(CLR), .REQ(REQ), .LOCK(LOCK), .WE(WE), .OE(OE),
        .A_0(A_0), .A_1(A_1), .A_2(A_2), .DI(DI),
        .GNT(GNT), .RDY(RDY), .DQ(DQ), .M_A(M_A), .M_DI(M_DI), .M_WE(M_WE),
        .M_OE(M_OE), .M_DQ(M_DQ), .BUSY(BUSY), .ERR(ERR)
    );

    typedef struct packed {
        logic [2:0]    gnt;
        logic [2:0]    rdy;
        logic [2:0]    dq;
        logic [AW-1:0] ma;
        logic          mdi;
        logic          mwe;
        logic          moe;
        logic          busy;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the port (-1 = nobody), whether it is locked, last served, hold cycles.
    int m_owner;
    bit m_locked;
    int m_last;
    int m_hold;
    bit m_err;

    function automatic int pick(input logic [2:0] req, input int last);
        for (int k = 1; k <= 3; k++)
            if (req[(last + k) % 3]) return (last + k) % 3;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_locked = 0; m_last = 2; m_hold = 0; m_err = 0;
    endtask

    task automatic model_release(input logic [2:0] req);
        m_last   = m_owner;
        m_owner  = pick(req, m_last);
        m_locked = 0;
    endtask

    task automatic model_step(input logic [2:0] req, input logic [2:0] lock);
        bit nerr;
        nerr = 0;
        if (m_owner < 0) begin
            m_owner  = pick(req, m_last);
            m_locked = 0;
        end else if (!(lock[m_owner] && req[m_owner])) begin
            model_release(req);
        end else if (!m_locked) begin
            m_locked = 1;
            m_hold   = 0;
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            if (m_hold == MAX_HOLD - 1) begin
                model_release(req);
                nerr = 1;
            end else begin
                m_hold++;
            end
`endif
        end
        m_err = nerr;
    endtask

    // Apply one cycle of inputs, queue the expected outputs, then advance the model over the next edge.
    task automatic step(input logic [2:0] req, input logic [2:0] lock, input logic [2:0] we,
                        input logic [2:0] oe, input logic [2:0] di, input logic [AW-1:0] a1,
                        input logic clr);
        exp_t          ex;
        logic [AW-1:0] addr [3];
        @(negedge CLK);
        REQ  = req; LOCK = lock; WE = we; OE = oe; DI = di;
        A_0  = AW'($urandom); A_1 = a1; A_2 = AW'($urandom);
        M_DQ = 1'($urandom_range(0, 1));
        CLR  = clr;
        addr[0] = A_0; addr[1] = A_1; addr[2] = A_2;
        if (!clr) model_reset();
        ex = '0;
        if (m_owner >= 0) begin
            ex.gnt[m_owner] = 1'b1;
            ex.rdy[m_owner] = req[m_owner];
            ex.dq[m_owner]  = M_DQ;
            ex.ma           = addr[m_owner];
            ex.mdi          = di[m_owner];
            ex.mwe          = we[m_owner] & req[m_owner];
            ex.moe          = oe[m_owner] & req[m_owner];
            ex.busy         = 1'b1;
        end
        ex.err = m_err;
        exp_q.push_back(ex);
        if (clr) model_step(req, lock);
    endtask

    // Monitor: every cycle the DUT presents outputs, pop and compare, plus structural invariants.
    initial begin
        forever begin
            exp_t ex, act;
            @(negedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                ex  = exp_q.pop_front();
                act = {GNT, RDY, DQ, M_A, M_DI, M_WE, M_OE, BUSY, ERR};
                checks++;
                if (act !== ex) begin
                    errors++;
                    $display("FAIL outputs t=%0t got gnt=%b rdy=%b dq=%b ma=%h di=%b we=%b oe=%b busy=%b err=%b; want gnt=%b rdy=%b dq=%b ma=%h di=%b we=%b oe=%b busy=%b err=%b",
                             $time, act.gnt, act.rdy, act.dq, act.ma, act.mdi, act.mwe, act.moe, act.busy, act.err,
                             ex.gnt, ex.rdy, ex.dq, ex.ma, ex.mdi, ex.mwe, ex.moe, ex.busy, ex.err);
                end
                checks++;
                if ($countones(GNT) > 1 || ((M_WE || M_OE) && ((GNT & REQ) == 3'b000))) begin
                    errors++;
                    $display("FAIL invariant t=%0t gnt=%b req=%b m_we=%b m_oe=%b; want <=1 grant and strobes only with granted REQ",
                             $time, GNT, REQ, M_WE, M_OE);
                end
            end
        end
    end

    initial begin
        logic [2:0] r_req, r_lock;
        CLR = 1'b0; REQ = '0; LOCK = '0; WE = '0; OE = '0; DI = '0;
        A_0 = '0; A_1 = '0; A_2 = '0; M_DQ = 1'b0;
        model_reset();

        // Reset held with everyone requesting, then release: grants rotate 0,1,2,0 with no gap.
        repeat (2) step(3'b111, 3'b000, 3'b000, 3'b111, 3'b000, AW'($urandom), 1'b0);
        repeat (6) step(3'b111, 3'b000, 3'b000, 3'b111, 3'b101, AW'($urandom), 1'b1);
        repeat (2) step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, AW'($urandom), 1'b1);

        // Single write from the word CPU, then idle.
        repeat (2) step(3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 12'h005, 1'b1);
        repeat (2) step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 12'h005, 1'b1);

        // CPU0 locks for several cycles while CPU2 waits, then releases.
        step(3'b001, 3'b001, 3'b001, 3'b000, 3'b001, AW'($urandom), 1'b1);
        repeat (6) step(3'b101, 3'b001, 3'b001, 3'b000, 3'b001, AW'($urandom), 1'b1);
        step(3'b101, 3'b000, 3'b001, 3'b000, 3'b001, AW'($urandom), 1'b1);
        repeat (2) step(3'b100, 3'b000, 3'b100, 3'b100, 3'b000, AW'($urandom), 1'b1);
        repeat (2) step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, AW'($urandom), 1'b1);

        // Owner drops REQ while granted with WE still high: no write strobe.
        step(3'b001, 3'b000, 3'b001, 3'b000, 3'b001, AW'($urandom), 1'b1);
        step(3'b000, 3'b000, 3'b001, 3'b000, 3'b001, AW'($urandom), 1'b1);
        step(3'b000, 3'b000, 3'b001, 3'b000, 3'b001, AW'($urandom), 1'b1);

        // Reset asserted in the middle of a locked write.
        repeat (3) step(3'b010, 3'b010, 3'b010, 3'b000, 3'b010, AW'($urandom), 1'b1);
        repeat (2) step(3'b010, 3'b010, 3'b010, 3'b000, 3'b010, AW'($urandom), 1'b0);
        repeat (2) step(3'b000, 3'b000, 3'b010, 3'b000, 3'b010, AW'($urandom), 1'b1);

        // Long lock by CPU1 with CPU0 waiting: held forever, or force-released with the hold limit.
        repeat (25) step(3'b011, 3'b010, 3'b011, 3'b000, 3'b011, AW'($urandom), 1'b1);
        repeat (3) step(3'b011, 3'b000, 3'b000, 3'b011, 3'b000, AW'($urandom), 1'b1);

        // Random traffic with sticky REQ/LOCK so locks last several cycles.
        r_req = 3'b000; r_lock = 3'b000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 3) == 0) r_req[b]  = ~r_req[b];
                if ($urandom_range(0, 7) == 0) r_lock[b] = ~r_lock[b];
            end
            step(r_req, r_lock, 3'($urandom), 3'($urandom), 3'($urandom), AW'($urandom),
                 ($urandom_range(0, 199) != 0));
        end

        repeat (3) @(negedge CLK);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
